fifo_pair_adder_reader: RTL and testbench
=========================================

Name: fifo_pair_adder_reader

Overview:
- Read-side consumer for two flip-flop FIFOs that hold operands A and B.
- Pops one word from each FIFO at the same time, but only when both FIFOs are non-empty.
- Passes the pair through a 2-stage stall-able pipeline (operand register, then sum register).
- Presents width+1-bit sums on a valid/ready output stream and keeps a count of delivered sums.

Parameters:
- width, 8, operand width of each FIFO read_data.
- count_width, 16, width of the delivered-sum counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- a_empty  in  1  empty flag of FIFO A.
- a_data  in  width  read_data of FIFO A; combinational, valid while a_empty=0.
- a_pop  out  1  pop strobe to FIFO A.
- b_empty  in  1  empty flag of FIFO B.
- b_data  in  width  read_data of FIFO B.
- b_pop  out  1  pop strobe to FIFO B.
- sum_valid  out  1  sum_data is valid.
- sum_ready  in  1  downstream accepts sum_data.
- sum_data  out  width+1  a + b, zero-extended, no truncation.
- sum_count  out  count_width  number of sums accepted downstream.
- busy  out  1  either pipeline stage holds data.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, sum_valid=0, sum_data=0, sum_count=0, busy=0.
- Reset outputs: a_pop=b_pop=0 while rst=1. Operand data registers need not be reset.
- Stage-advance rules:
  - s2_advance = ~s2_valid | sum_ready.
  - s1_advance = ~s1_valid | s2_advance.
- Pop rule: a_pop = b_pop = ~a_empty & ~b_empty & s1_advance.
  - Both pops are always asserted in the same cycle.
  - A pop is never issued to an empty FIFO.
  - If one FIFO is non-empty and the other is empty, neither is popped; the pending word stays in its FIFO.
- Stage 1 (clock edge with s1_advance=1):
  - s1_valid <= pop.
  - If pop: s1_a <= a_data, s1_b <= b_data.
- Stage 2 (clock edge with s2_advance=1):
  - s2_valid <= s1_valid.
  - If s1_valid: sum_data <= {1'b0,s1_a} + {1'b0,s1_b}.
- Stall: when sum_valid=1 and sum_ready=0, sum_data and all stage registers hold unchanged. No pop occurs unless stage 1 is empty.
- Outputs: sum_valid = s2_valid; busy = s1_valid | s2_valid.
- Latency: pop in cycle N -> sum_valid=1 in cycle N+2 (no stall). Throughput is one sum per cycle with sum_ready held at 1.
- Counter: sum_count increments by 1 on each cycle where sum_valid & sum_ready. It wraps modulo 2^count_width with no saturation.
- Overflow: the carry is kept in sum_data[width]. Example with width=8: 255+255 -> 9'h1FE.
- Path note: sum_ready -> a_pop/b_pop is a combinational path (FIFO pop is sampled at the next edge). This is intended.
- Protocol: once sum_valid=1, sum_data stays stable until accepted.
- Reset mid-operation: in-flight pairs in both stages are discarded, and sum_count returns to 0. Words already popped are lost; the FIFOs must be reset together with this block.

Test Plan:
- Reset/idle: hold rst=1 with FIFOs non-empty -> a_pop=b_pop=0, sum_valid=0, sum_count=0. After rst=0 with both FIFOs empty -> no pops and busy=0 indefinitely.
- Streaming, latency and throughput: A={1,2,3}, B={10,20,30}, sum_ready=1.
  - Pops occur in cycles 0,1,2.
  - sum_valid is high in cycles 2,3,4 with sum_data 11,22,33.
  - sum_count ends at 3.
- Unbalanced FIFOs: A holds 2 words, B is empty for 5 cycles, then B is given {5,6} -> no pops during the 5 cycles. Sums are A0+5 and A1+6, in order.
- Backpressure: stream 4 pairs with sum_ready=0 from cycle 3 to 8.
  - sum_data holds its first value while stalled.
  - At most 2 pairs are popped while both stages are full.
  - After release, all 4 sums appear in order with none lost or duplicated.
- Carry: width=8, A=255, B=255 -> sum_data=9'h1FE. A=128, B=128 -> 9'h100.
- Async reset mid-stream: assert rst between clock edges while both stages are valid -> sum_valid=0 and sum_count=0 immediately, before the next edge. Restarting the FIFOs yields correct sums.

Source files
------------

// File: rtl/fifo_pair_adder_reader.sv
// fifo_pair_adder_reader: pops operand pairs from two FIFOs in lockstep and streams
// their width+1-bit sums through a two-stage stall-able pipeline with a delivery counter.
module fifo_pair_adder_reader #(
    parameter int width       = 8,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_empty_i,
    input  logic [width-1:0]       a_data_i,
    output logic                   a_pop_o,
    input  logic                   b_empty_i,
    input  logic [width-1:0]       b_data_i,
    output logic                   b_pop_o,
    output logic                   sum_valid_o,
    input  logic                   sum_ready_i,
    output logic [width:0]         sum_data_o,
    output logic [count_width-1:0] sum_count_o,
    output logic                   busy_o
);
    logic                   s1_valid_q, s1_valid_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [width-1:0]       s1_a_q, s1_b_q;
    logic [width:0]         sum_q, sum_d;
    logic [count_width-1:0] count_q, count_d;
    logic                   s1_adv, s2_adv, pop;
    always_comb begin
        s2_adv     = ~s2_valid_q | sum_ready_i;
        s1_adv     = ~s1_valid_q | s2_adv;
        // pop is suppressed during reset so neither FIFO loses a word while we are held
        pop        = ~rst & ~a_empty_i & ~b_empty_i & s1_adv;
        s1_valid_d = s1_adv ? pop : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        sum_d      = (s2_adv & s1_valid_q) ? {1'b0, s1_a_q} + {1'b0, s1_b_q} : sum_q;
        count_d    = count_q + count_width'(s2_valid_q & sum_ready_i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (pop) begin
            s1_a_q <= a_data_i;
            s1_b_q <= b_data_i;
        end
    end
    assign a_pop_o     = pop;
    assign b_pop_o     = pop;
    assign sum_valid_o = s2_valid_q;
    assign sum_data_o  = sum_q;
    assign sum_count_o = count_q;
    assign busy_o      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_fifo_pair_adder_reader.sv
// tb_fifo_pair_adder_reader: FIFO models feed the reader; a scoreboard queue holds
// hand-computed sums and a negedge monitor checks every accepted output against it.
module tb_fifo_pair_adder_reader;
    localparam int W  = 8;
    localparam int CW = 16;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_empty_i = 1'b1, b_empty_i = 1'b1;
    logic [W-1:0]  a_data_i = '0, b_data_i = '0;
    logic          a_pop_o, b_pop_o, sum_valid_o, busy_o;
    logic          sum_ready_i = 1'b1;
    logic [W:0]    sum_data_o;
    logic [CW-1:0] sum_count_o;
    logic [W-1:0]  qa[$], qb[$];
    logic [W:0]    exp_q[$];
    logic          pa, pb;
    int            vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    fifo_pair_adder_reader #(.width(W), .count_width(CW)) dut (
        .clk(clk), .rst(rst),
        .a_empty_i(a_empty_i), .a_data_i(a_data_i), .a_pop_o(a_pop_o),
        .b_empty_i(b_empty_i), .b_data_i(b_data_i), .b_pop_o(b_pop_o),
        .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i), .sum_data_o(sum_data_o),
        .sum_count_o(sum_count_o), .busy_o(busy_o)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask
    task automatic refresh();
        a_empty_i = (qa.size() == 0);
        b_empty_i = (qb.size() == 0);
        a_data_i  = (qa.size() != 0) ? qa[0] : '0;
        b_data_i  = (qb.size() != 0) ? qb[0] : '0;
    endtask
    // FIFO models: pops sampled at the edge, applied 1 time unit later
    always begin
        @(posedge clk);
        pa = a_pop_o;
        pb = b_pop_o;
        #1;
        if (pa) check("pop_a_nonempty", 32'(qa.size() != 0), 1);
        if (pb) check("pop_b_nonempty", 32'(qb.size() != 0), 1);
        if (pa && qa.size() != 0) void'(qa.pop_front());
        if (pb && qb.size() != 0) void'(qb.pop_front());
        refresh();
        #2;
        refresh();
    end
    always @(negedge clk) begin
        if (!rst && sum_valid_o && sum_ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_sum: got %0d expected none", sum_data_o);
            end else check("sum_data", 32'(sum_data_o), 32'(exp_q.pop_front()));
        end
    end
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
        qa.push_back(a);
        qb.push_back(b);
        exp_q.push_back(e);
    endtask
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 60) begin
            cyc();
            n++;
        end
        check("drain_in_time", 32'(n < 60), 1);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        logic [13:0] pops, bpops, vals;
        logic        seen_pop, seen_busy;
        int          held;
        qa.push_back(8'd1);
        qb.push_back(8'd2);
        repeat (2) @(negedge clk);
        check("rst_a_pop", 32'(a_pop_o), 0);
        check("rst_b_pop", 32'(b_pop_o), 0);
        check("rst_sum_valid", 32'(sum_valid_o), 0);
        check("rst_sum_count", 32'(sum_count_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        cyc();
        qa.delete();
        qb.delete();
        cyc();
        rst = 1'b0;
        seen_pop = 0;
        seen_busy = 0;
        repeat (5) begin
            @(negedge clk);
            seen_pop |= a_pop_o | b_pop_o;
            seen_busy |= busy_o;
        end
        check("idle_no_pop", 32'(seen_pop), 0);
        check("idle_not_busy", 32'(seen_busy), 0);
        cyc();
        push_pair(8'd1, 8'd10, 9'd11);
        push_pair(8'd2, 8'd20, 9'd22);
        push_pair(8'd3, 8'd30, 9'd33);
        pops = '0; bpops = '0; vals = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            pops[c] = a_pop_o;
            bpops[c] = b_pop_o;
            vals[c] = sum_valid_o;
        end
        check("stream_a_pops", 32'(pops), 32'h07);
        check("stream_b_pops", 32'(bpops), 32'h07);
        check("stream_valid_cycles", 32'(vals), 32'h1C);
        check("stream_count", 32'(sum_count_o), 3);
        drain();
        cyc();
        qa.push_back(8'd9);
        qa.push_back(8'd40);
        seen_pop = 0;
        seen_busy = 0;
        repeat (5) begin
            @(negedge clk);
            seen_pop |= a_pop_o | b_pop_o;
            seen_busy |= busy_o;
        end
        check("unbal_no_pop", 32'(seen_pop), 0);
        check("unbal_not_busy", 32'(seen_busy), 0);
        cyc();
        qb.push_back(8'd5);
        qb.push_back(8'd6);
        exp_q.push_back(9'd14);
        exp_q.push_back(9'd46);
        drain();
        check("unbal_count", 32'(sum_count_o), 5);
        cyc();
        push_pair(8'd7, 8'd1, 9'd8);
        push_pair(8'd100, 8'd50, 9'd150);
        push_pair(8'd3, 8'd4, 9'd7);
        push_pair(8'd200, 8'd100, 9'h12C);
        pops = '0;
        held = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) cyc();
            sum_ready_i = !(c >= 3 && c <= 8);
            @(negedge clk);
            pops[c] = a_pop_o;
            if (c >= 3 && c <= 8 && sum_valid_o && sum_data_o == 9'd150) held++;
        end
        sum_ready_i = 1'b1;
        check("bp_pop_cycles", 32'(pops), 32'h207);
        check("bp_held_cycles", 32'(held), 6);
        drain();
        check("bp_count", 32'(sum_count_o), 9);
        cyc();
        push_pair(8'd255, 8'd255, 9'h1FE);
        push_pair(8'd128, 8'd128, 9'h100);
        drain();
        check("carry_count", 32'(sum_count_o), 11);
        cyc();
        push_pair(8'd1, 8'd1, 9'd2);
        push_pair(8'd2, 8'd2, 9'd4);
        push_pair(8'd3, 8'd3, 9'd6);
        push_pair(8'd4, 8'd4, 9'd8);
        cyc();
        cyc();
        check("mid_busy_before", 32'(busy_o), 1);
        check("mid_valid_before", 32'(sum_valid_o), 1);
        qa.delete();
        qb.delete();
        exp_q.delete();
        #1 rst = 1'b1;
        #1;
        check("async_sum_valid", 32'(sum_valid_o), 0);
        check("async_sum_count", 32'(sum_count_o), 0);
        check("async_busy", 32'(busy_o), 0);
        check("async_a_pop", 32'(a_pop_o), 0);
        cyc();
        cyc();
        rst = 1'b0;
        push_pair(8'd2, 8'd3, 9'd5);
        push_pair(8'd17, 8'd17, 9'd34);
        drain();
        check("restart_count", 32'(sum_count_o), 2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
